// File: rtl/input_conditioner.sv
// Synchronises and debounces the board push-button and 3-bit slide switch for the pattern controller.
// Optional long-press strobe is built only when LONG_PRESS_EN is defined; otherwise long_press is tied 0.
//
// Button FSM states:
//   state     | meaning
//   IDLE_LOW  | button accepted as released, watching for a high sample
//   WAIT_HIGH | high seen, counting consecutive high samples
//   IDLE_HIGH | button accepted as pressed, watching for a low sample
//   WAIT_LOW  | low seen, counting consecutive low samples
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES   = 2000000,
  parameter int CNT_W             = 32,
  parameter int LONG_PRESS_CYCLES = 100000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       button_raw,
  input  logic [2:0] switch_raw,
  output logic       button_level,
  output logic       button_pulse,
  output logic [2:0] switch_stable,
  output logic       switch_changed,
  output logic       long_press
);

  // The cycle that first sees the new value counts as the first stable sample,
  // so the counter only has to cover the remaining DEBOUNCE_CYCLES-1 samples.
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("input_conditioner: DEBOUNCE_CYCLES must be >= 2");
  end
  if (LONG_PRESS_CYCLES < 1) begin : g_bad_long_press
    $error("input_conditioner: LONG_PRESS_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } btn_state_t;

  logic             btn_m, btn_s;
  logic [2:0]       sw_m, sw_s, sw_prev;
  btn_state_t       btn_state;
  logic [CNT_W-1:0] btn_cnt;
  logic [CNT_W-1:0] sw_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_m <= 1'b0;
      btn_s <= 1'b0;
      sw_m  <= 3'b000;
      sw_s  <= 3'b000;
    end else begin
      btn_m <= button_raw;
      btn_s <= btn_m;
      sw_m  <= switch_raw;
      sw_s  <= sw_m;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_state    <= IDLE_LOW;
      btn_cnt      <= '0;
      button_level <= 1'b0;
      button_pulse <= 1'b0;
    end else begin
      button_pulse <= 1'b0;
      case (btn_state)
        IDLE_LOW: begin
          btn_cnt <= '0;
          if (btn_s) btn_state <= WAIT_HIGH;
        end
        WAIT_HIGH: begin
          if (!btn_s) begin
            btn_state <= IDLE_LOW;
            btn_cnt   <= '0;
          end else if (btn_cnt == DB_LAST) begin
            btn_state    <= IDLE_HIGH;
            btn_cnt      <= '0;
            button_level <= 1'b1;
            button_pulse <= 1'b1;
          end else begin
            btn_cnt <= btn_cnt + CNT_W'(1);
          end
        end
        IDLE_HIGH: begin
          btn_cnt <= '0;
          if (!btn_s) btn_state <= WAIT_LOW;
        end
        WAIT_LOW: begin
          if (btn_s) begin
            btn_state <= IDLE_HIGH;
            btn_cnt   <= '0;
          end else if (btn_cnt == DB_LAST) begin
            btn_state    <= IDLE_LOW;
            btn_cnt      <= '0;
            button_level <= 1'b0;
          end else begin
            btn_cnt <= btn_cnt + CNT_W'(1);
          end
        end
        default: begin
          btn_state <= IDLE_LOW;
          btn_cnt   <= '0;
        end
      endcase
    end
  end

  // One counter for the whole vector: any bit moving restarts the wait.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_prev        <= 3'b000;
      sw_cnt         <= '0;
      switch_stable  <= 3'b000;
      switch_changed <= 1'b0;
    end else begin
      sw_prev        <= sw_s;
      switch_changed <= 1'b0;
      if ((sw_s == switch_stable) || (sw_s != sw_prev)) begin
        sw_cnt <= '0;
      end else if (sw_cnt == DB_LAST) begin
        sw_cnt         <= '0;
        switch_stable  <= sw_s;
        switch_changed <= 1'b1;
      end else begin
        sw_cnt <= sw_cnt + CNT_W'(1);
      end
    end
  end

`ifdef LONG_PRESS_EN
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);

  logic [CNT_W-1:0] hold_cnt;
  logic             hold_done;
  logic             long_q;

  // Counter parks at LP_LAST; hold_done keeps a long hold to a single strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt  <= '0;
      hold_done <= 1'b0;
      long_q    <= 1'b0;
    end else if (!button_level) begin
      hold_cnt  <= '0;
      hold_done <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      long_q <= 1'b0;
      if (hold_cnt != LP_LAST) begin
        hold_cnt <= hold_cnt + CNT_W'(1);
      end else if (!hold_done) begin
        hold_done <= 1'b1;
        long_q    <= 1'b1;
      end
    end
  end

  assign long_press = long_q;
`else
  assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with DEBOUNCE_CYCLES=4 and LONG_PRESS_CYCLES=16.
// Long-press expectations follow LONG_PRESS_EN when it is defined for the build.
module tb_input_conditioner;

  localparam int DB = 4;
  localparam int LP = 16;
  localparam int LAT = DB + 1;  // edges from first raw sample to committed output

  logic       clk = 1'b0;
  logic       rst;
  logic       button_raw;
  logic [2:0] switch_raw;
  logic       button_level;
  logic       button_pulse;
  logic [2:0] switch_stable;
  logic       switch_changed;
  logic       long_press;

  int n_cmp = 0;
  int n_err = 0;

  input_conditioner #(
    .DEBOUNCE_CYCLES  (DB),
    .CNT_W            (32),
    .LONG_PRESS_CYCLES(LP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .button_raw    (button_raw),
    .switch_raw    (switch_raw),
    .button_level  (button_level),
    .button_pulse  (button_pulse),
    .switch_stable (switch_stable),
    .switch_changed(switch_changed),
    .long_press    (long_press)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n_pulse;
    int n_long;
    int exp_long_cnt;

    rst        = 1'b1;
    button_raw = 1'b0;
    switch_raw = 3'b000;

    // reset with raw inputs toggling
    for (int i = 0; i < 3; i++) begin
      button_raw = ~button_raw;
      switch_raw = ~switch_raw;
      tick();
      check($sformatf("reset.outs@%0d", i),
            {25'd0, button_level, button_pulse, switch_stable, switch_changed, long_press}, 32'd0);
    end
    button_raw = 1'b0;
    switch_raw = 3'b000;
    rst        = 1'b0;
    repeat (6) tick();
    check("idle.outs", {25'd0, button_level, button_pulse, switch_stable, switch_changed, long_press}, 32'd0);

    // clean press, then release
    button_raw = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      check($sformatf("press.level@%0d", k), button_level, (k >= LAT + 1));
      check($sformatf("press.pulse@%0d", k), button_pulse, (k == LAT + 1));
    end
    button_raw = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check($sformatf("release.level@%0d", k), button_level, (k < LAT + 1));
      check($sformatf("release.pulse@%0d", k), button_pulse, 1'b0);
    end

    // bounce: 1,1,0,0,1,1,0,0 then steady high from edge 9
    n_pulse = 0;
    for (int k = 1; k <= 24; k++) begin
      button_raw = (k >= 9) ? 1'b1 : ((((k - 1) / 2) % 2) == 0);
      tick();
      check($sformatf("bounce.level@%0d", k), button_level, (k >= 9 + LAT));
      if (button_pulse) n_pulse++;
    end
    check("bounce.pulse_count", n_pulse, 1);

    // switch 000 -> 101
    switch_raw = 3'b101;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check($sformatf("sw.stable@%0d", k), switch_stable, (k >= LAT + 1) ? 3'b101 : 3'b000);
      check($sformatf("sw.changed@%0d", k), switch_changed, (k == LAT + 1));
    end

    // two-cycle glitch to 111 must be rejected
    for (int k = 1; k <= 12; k++) begin
      switch_raw = (k <= 2) ? 3'b111 : 3'b101;
      tick();
      check($sformatf("glitch.stable@%0d", k), switch_stable, 3'b101);
      check($sformatf("glitch.changed@%0d", k), switch_changed, 1'b0);
    end

    // button release and switch change commit on the same edge
    button_raw = 1'b0;
    switch_raw = 3'b010;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check($sformatf("simul.level@%0d", k), button_level, (k < LAT + 1));
      check($sformatf("simul.pulse@%0d", k), button_pulse, 1'b0);
      check($sformatf("simul.stable@%0d", k), switch_stable, (k >= LAT + 1) ? 3'b010 : 3'b101);
      check($sformatf("simul.changed@%0d", k), switch_changed, (k == LAT + 1));
    end

    // reset at edge 4 discards the partial count
    button_raw = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      rst = (k == 4);
      tick();
      check($sformatf("rstmid.level@%0d", k), button_level, (k >= 4 + LAT + 1));
      check($sformatf("rstmid.pulse@%0d", k), button_pulse, (k == 4 + LAT + 1));
      check($sformatf("rstmid.stable@%0d", k), switch_stable,
            (k >= 4 && k < 4 + LAT + 1) ? 3'b000 : 3'b010);
      check($sformatf("rstmid.changed@%0d", k), switch_changed, (k == 4 + LAT + 1));
    end
    rst = 1'b0;

    // long hold
    button_raw = 1'b0;
    repeat (12) tick();
    check("long.pre_level", button_level, 1'b0);
    button_raw = 1'b1;
    n_long = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      check($sformatf("long.level@%0d", k), button_level, (k >= LAT + 1));
`ifdef LONG_PRESS_EN
      check($sformatf("long.pulse@%0d", k), long_press, (k == LAT + 1 + LP));
`else
      check($sformatf("long.pulse@%0d", k), long_press, 1'b0);
`endif
      if (long_press) n_long++;
    end
`ifdef LONG_PRESS_EN
    exp_long_cnt = 1;
`else
    exp_long_cnt = 0;
`endif
    check("long.pulse_count", n_long, exp_long_cnt);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
